// File: rtl/cpu_core_p_if.sv
// Bus bundle for cpu_core_p: instruction handshake, data-memory port and
// status outputs. The core attaches through the slave modport; the
// surrounding system (instruction source and memory) uses master.
interface cpu_core_p_if #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 4,
   parameter int MEM_AW = 8
);
   localparam int INSTR_W = 4 + REG_AW + DATA_W;

   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;

   logic               mem_req;
   logic               mem_we;
   logic [MEM_AW-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic [DATA_W-1:0]  mem_rdata;
   logic               mem_ack;

   logic [DATA_W-1:0]  result;
   logic               result_valid;
   logic               flag_z;
   logic               flag_c;
   logic               halted;

   modport master (
      output instr, instr_valid, mem_rdata, mem_ack,
      input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata,
             result, result_valid, flag_z, flag_c, halted
   );

   modport slave (
      input  instr, instr_valid, mem_rdata, mem_ack,
      output instr_ready, mem_req, mem_we, mem_addr, mem_wdata,
             result, result_valid, flag_z, flag_c, halted
   );
endinterface

// File: rtl/cpu_core_p.sv
// cpu_core_p: multi-cycle core executing one instruction at a time from an
// internal register file, with zero/carry flags, a variable-latency
// request/acknowledge data-memory port and a terminal HALT state.
module cpu_core_p #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 4,
   parameter int MEM_AW = 8
) (
   input logic         clk,
   input logic         reset,
   cpu_core_p_if.slave bus
);
   localparam int NREGS   = 2 ** REG_AW;
   localparam int INSTR_W = 4 + REG_AW + DATA_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MEM  = 2'd2;
   localparam logic [1:0] S_HALT = 2'd3;

   localparam logic [2:0] OP_LDI  = 3'b000;
   localparam logic [2:0] OP_ST   = 3'b001;
   localparam logic [2:0] OP_LD   = 3'b010;
   localparam logic [2:0] OP_ADDI = 3'b011;
   localparam logic [2:0] OP_SUBI = 3'b100;
   localparam logic [2:0] OP_ANDI = 3'b101;
   localparam logic [2:0] OP_XORI = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   logic [1:0]        state;
   logic [2:0]        ir_op;
   logic [REG_AW-1:0] ir_rd;
   logic [DATA_W-1:0] ir_imm;
   logic [DATA_W-1:0] regs [NREGS];

   logic [DATA_W-1:0] result;
   logic              result_valid;
   logic              flag_z;
   logic              flag_c;
   logic              mem_req;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   // Fields of the instruction currently offered; the top bit is reserved.
   logic [2:0]        in_op;
   logic [REG_AW-1:0] in_rd;
   logic [DATA_W-1:0] in_imm;
   logic              unused_rsvd;

   assign in_op       = bus.instr[INSTR_W-2 -: 3];
   assign in_rd       = bus.instr[DATA_W+REG_AW-1 : DATA_W];
   assign in_imm      = bus.instr[DATA_W-1:0];
   assign unused_rsvd = bus.instr[INSTR_W-1];

   // ALU results for the latched instruction, consumed in EXEC.
   logic [DATA_W-1:0] alu_r;
   logic [DATA_W:0]   alu_sum;
   logic [DATA_W:0]   alu_diff;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;
   logic              alu_upd_z;
   logic              alu_upd_c;

   assign alu_r    = regs[ir_rd];
   assign alu_sum  = {1'b0, alu_r} + {1'b0, ir_imm};
   // Top bit of the widened difference is the unsigned borrow (r < imm).
   assign alu_diff = {1'b0, alu_r} - {1'b0, ir_imm};

   // Select the ALU result and which flags the op is allowed to touch.
   always_comb begin
      alu_res   = ir_imm;
      alu_c     = 1'b0;
      alu_upd_z = 1'b0;
      alu_upd_c = 1'b0;
      case (ir_op)
         OP_ADDI: begin
            alu_res   = alu_sum[DATA_W-1:0];
            alu_c     = alu_sum[DATA_W];
            alu_upd_z = 1'b1;
            alu_upd_c = 1'b1;
         end
         OP_SUBI: begin
            alu_res   = alu_diff[DATA_W-1:0];
            alu_c     = alu_diff[DATA_W];
            alu_upd_z = 1'b1;
            alu_upd_c = 1'b1;
         end
         OP_ANDI: begin
            alu_res   = alu_r & ir_imm;
            alu_upd_z = 1'b1;
            alu_upd_c = 1'b1;
         end
         OP_XORI: begin
            alu_res   = alu_r ^ ir_imm;
            alu_upd_z = 1'b1;
            alu_upd_c = 1'b1;
         end
         default: alu_res = ir_imm;  // LDI; no flag update
      endcase
   end

   // Register file write-back from the ALU (EXEC) or from a completed load.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (state == S_EXEC) begin
         regs[ir_rd] <= alu_res;
      end else if (state == S_MEM && bus.mem_ack && ir_op == OP_LD) begin
         regs[ir_rd] <= bus.mem_rdata;
      end
   end

   // Sequencer: accept, execute, drive the memory handshake, publish result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         ir_op        <= OP_LDI;
         ir_rd        <= '0;
         ir_imm       <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         flag_z       <= 1'b0;
         flag_c       <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.instr_valid) begin
                  ir_op  <= in_op;
                  ir_rd  <= in_rd;
                  ir_imm <= in_imm;
                  case (in_op)
                     OP_ST, OP_LD: begin
                        state     <= S_MEM;
                        mem_req   <= 1'b1;
                        mem_we    <= (in_op == OP_ST);
                        mem_addr  <= in_imm[MEM_AW-1:0];
                        mem_wdata <= regs[in_rd];
                     end
                     OP_HALT: state <= S_HALT;
                     default: state <= S_EXEC;
                  endcase
               end
            end
            S_EXEC: begin
               result       <= alu_res;
               result_valid <= 1'b1;
               if (alu_upd_z) flag_z <= (alu_res == '0);
               if (alu_upd_c) flag_c <= alu_c;
               state <= S_IDLE;
            end
            S_MEM: begin
               if (bus.mem_ack) begin
                  mem_req      <= 1'b0;
                  result       <= (ir_op == OP_LD) ? bus.mem_rdata : mem_wdata;
                  result_valid <= 1'b1;
                  state        <= S_IDLE;
               end
            end
            S_HALT: state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.instr_ready  = (state == S_IDLE);
   assign bus.halted       = (state == S_HALT);
   assign bus.mem_req      = mem_req;
   assign bus.mem_we       = mem_we;
   assign bus.mem_addr     = mem_addr;
   assign bus.mem_wdata    = mem_wdata;
   assign bus.result       = result;
   assign bus.result_valid = result_valid;
   assign bus.flag_z       = flag_z;
   assign bus.flag_c       = flag_c;
endmodule

// File: tb/tb_cpu_core_p.sv
// Self-checking bench for cpu_core_p: a reference register/flag model pushes
// expected write-back values into a queue at issue time, and a monitor pops
// and compares them whenever result_valid is seen.
module tb_cpu_core_p;
   localparam logic [2:0] OP_LDI  = 3'b000;
   localparam logic [2:0] OP_ST   = 3'b001;
   localparam logic [2:0] OP_LD   = 3'b010;
   localparam logic [2:0] OP_ADDI = 3'b011;
   localparam logic [2:0] OP_SUBI = 3'b100;
   localparam logic [2:0] OP_ANDI = 3'b101;
   localparam logic [2:0] OP_XORI = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   logic clk;
   logic reset;

   cpu_core_p_if #(.DATA_W(8), .REG_AW(4), .MEM_AW(8)) bus ();

   cpu_core_p #(.DATA_W(8), .REG_AW(4), .MEM_AW(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;
   logic [7:0] mreg [16];
   logic       mz;
   logic       mc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard monitor: every result_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (bus.result_valid) begin
         if (exp_q.size() == 0) begin
            check_val("rv_unexpected", {31'b0, bus.result_valid}, 32'(exp_q.size()));
         end else begin
            exp_v = exp_q.pop_front();
            check_val("result", {24'b0, bus.result}, {24'b0, exp_v});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
      mz = 1'b0;
      mc = 1'b0;
   endtask

   // Called on a falling edge; returns on the falling edge after acceptance.
   task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [7:0] imm);
      int n = 0;
      while (!bus.instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("issue_ready", {31'b0, bus.instr_ready}, 32'd1);
      bus.instr       = {1'($urandom_range(0, 1)), op, rd, imm};
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check_val("accepted", {31'b0, bus.instr_ready}, 32'd0);
   endtask

   task automatic alu_op(input logic [2:0] op, input logic [3:0] rd, input logic [7:0] imm);
      logic [8:0] t;
      logic [7:0] r;
      logic [7:0] v;
      r = mreg[rd];
      v = imm;
      case (op)
         OP_ADDI: begin
            t  = {1'b0, r} + {1'b0, imm};
            v  = t[7:0];
            mc = t[8];
            mz = (v == 8'h00);
         end
         OP_SUBI: begin
            v  = r - imm;
            mc = (r < imm);
            mz = (v == 8'h00);
         end
         OP_ANDI: begin
            v  = r & imm;
            mc = 1'b0;
            mz = (v == 8'h00);
         end
         OP_XORI: begin
            v  = r ^ imm;
            mc = 1'b0;
            mz = (v == 8'h00);
         end
         default: v = imm;
      endcase
      mreg[rd] = v;
      exp_q.push_back(v);
      issue(op, rd, imm);
      @(negedge clk);
      check_val("alu_rv", {31'b0, bus.result_valid}, 32'd1);
      check_val("flag_z", {31'b0, bus.flag_z}, {31'b0, mz});
      check_val("flag_c", {31'b0, bus.flag_c}, {31'b0, mc});
   endtask

   task automatic mem_op(input logic st, input logic [3:0] rd, input logic [7:0] addr,
                         input int waits, input logic [7:0] rdata);
      logic [7:0] wd;
      wd = mreg[rd];
      exp_q.push_back(st ? wd : rdata);
      issue(st ? OP_ST : OP_LD, rd, addr);
      for (int i = 0; i <= waits; i++) begin
         check_val("mem_req_hold", {31'b0, bus.mem_req}, 32'd1);
         check_val("mem_we", {31'b0, bus.mem_we}, {31'b0, st});
         check_val("mem_addr", {24'b0, bus.mem_addr}, {24'b0, addr});
         check_val("mem_wdata", {24'b0, bus.mem_wdata}, {24'b0, wd});
         check_val("mem_busy_ready", {31'b0, bus.instr_ready}, 32'd0);
         check_val("mem_busy_rv", {31'b0, bus.result_valid}, 32'd0);
         if (i == waits) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdata;
         end
         @(negedge clk);
      end
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'hEE;
      check_val("mem_req_drop", {31'b0, bus.mem_req}, 32'd0);
      check_val("mem_rv", {31'b0, bus.result_valid}, 32'd1);
      check_val("mem_flag_z", {31'b0, bus.flag_z}, {31'b0, mz});
      check_val("mem_flag_c", {31'b0, bus.flag_c}, {31'b0, mc});
      if (!st) mreg[rd] = rdata;
   endtask

   task automatic check_reset_state();
      check_val("rst_ready", {31'b0, bus.instr_ready}, 32'd1);
      check_val("rst_halted", {31'b0, bus.halted}, 32'd0);
      check_val("rst_result", {24'b0, bus.result}, 32'd0);
      check_val("rst_rv", {31'b0, bus.result_valid}, 32'd0);
      check_val("rst_flags", {30'b0, bus.flag_z, bus.flag_c}, 32'd0);
      check_val("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
      check_val("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
      check_val("rst_mem_addr", {24'b0, bus.mem_addr}, 32'd0);
      check_val("rst_mem_wdata", {24'b0, bus.mem_wdata}, 32'd0);
   endtask

   initial begin
      reset           = 1'b1;
      bus.instr       = '0;
      bus.instr_valid = 1'b0;
      bus.mem_ack     = 1'b0;
      bus.mem_rdata   = 8'h00;
      model_clear();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_state();

      // First LDI: write-back two edges after accept, ready low for one cycle.
      mreg[3] = 8'h5A;
      exp_q.push_back(8'h5A);
      issue(OP_LDI, 4'd3, 8'h5A);
      check_val("ldi_rv_early", {31'b0, bus.result_valid}, 32'd0);
      @(negedge clk);
      check_val("ldi_rv", {31'b0, bus.result_valid}, 32'd1);
      check_val("ldi_ready_back", {31'b0, bus.instr_ready}, 32'd1);
      check_val("ldi_flags", {30'b0, bus.flag_z, bus.flag_c}, 32'd0);

      // Arithmetic, carry/borrow and zero flags.
      alu_op(OP_LDI,  4'd1, 8'hF0);
      alu_op(OP_ADDI, 4'd1, 8'h20);
      alu_op(OP_SUBI, 4'd1, 8'h10);
      alu_op(OP_SUBI, 4'd1, 8'h01);
      alu_op(OP_ANDI, 4'd3, 8'h0F);
      alu_op(OP_XORI, 4'd3, 8'h0A);
      alu_op(OP_LDI,  4'd5, 8'h00);
      alu_op(OP_ADDI, 4'd4, 8'hFF);
      alu_op(OP_ADDI, 4'd4, 8'h01);
      alu_op(OP_SUBI, 4'd1, 8'hFF);

      // Store with three wait states, load, then store the loaded register back.
      alu_op(OP_SUBI, 4'd1, 8'h01);
      mem_op(1'b1, 4'd1, 8'h40, 3, 8'h00);
      mem_op(1'b0, 4'd2, 8'h40, 1, 8'hA5);
      mem_op(1'b1, 4'd2, 8'h41, 0, 8'h00);

      // Stray acknowledge while idle must not produce a write-back.
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'h77;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      @(negedge clk);
      check_val("idle_ack_req", {31'b0, bus.mem_req}, 32'd0);
      check_val("idle_ack_result", {24'b0, bus.result}, {24'b0, mreg[2]});
      check_val("idle_ack_ready", {31'b0, bus.instr_ready}, 32'd1);

      // HALT holds off further instructions until reset.
      issue(OP_HALT, 4'd0, 8'h00);
      check_val("halted", {31'b0, bus.halted}, 32'd1);
      bus.instr       = {1'b0, OP_LDI, 4'd1, 8'h11};
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("halt_stay", {31'b0, bus.halted}, 32'd1);
         check_val("halt_ready", {31'b0, bus.instr_ready}, 32'd0);
         check_val("halt_rv", {31'b0, bus.result_valid}, 32'd0);
      end
      bus.instr_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      check_reset_state();
      for (int i = 0; i < 16; i++) mem_op(1'b1, 4'(i), 8'(i), 0, 8'h00);

      // Reset while a load waits for its acknowledge; a late ack is ignored.
      alu_op(OP_LDI, 4'd6, 8'h66);
      issue(OP_LD, 4'd6, 8'h10);
      check_val("abort_req", {31'b0, bus.mem_req}, 32'd1);
      @(negedge clk);
      check_val("abort_req_wait", {31'b0, bus.mem_req}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      check_val("abort_req_drop", {31'b0, bus.mem_req}, 32'd0);
      check_val("abort_ready", {31'b0, bus.instr_ready}, 32'd1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'h99;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      @(negedge clk);
      check_val("late_ack_result", {24'b0, bus.result}, 32'd0);
      check_val("late_ack_ready", {31'b0, bus.instr_ready}, 32'd1);
      alu_op(OP_LDI, 4'd7, 8'h33);
      mem_op(1'b1, 4'd6, 8'h20, 0, 8'h00);
      mem_op(1'b1, 4'd7, 8'h21, 2, 8'h00);

      repeat (3) @(negedge clk);
      check_val("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
